// File: rtl/min_max_tracker_8_bit.sv
// min_max_tracker_8_bit: per-block running max/min of an unsigned 8-bit sample stream.
// Ports:
//   Clock_In, Reset_In (async, active-high), Clear_In (sync abort),
//   Data_Valid_In/Data_In (sample in), Busy_Out, Sample_Count_Out,
//   Max_Out/Min_Out with first-occurrence Max_Index_Out/Min_Index_Out,
//   Result_Valid_Out (one-cycle strobe when a block result is published).
module min_max_tracker_8_bit #(
    parameter int BLOCK_LENGTH = 16,
    localparam int IDX_W = $clog2(BLOCK_LENGTH)
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Clear_In,
    input  logic             Data_Valid_In,
    input  logic [7:0]       Data_In,
    output logic             Busy_Out,
    output logic [IDX_W-1:0] Sample_Count_Out,
    output logic [7:0]       Max_Out,
    output logic [7:0]       Min_Out,
    output logic [IDX_W-1:0] Max_Index_Out,
    output logic [IDX_W-1:0] Min_Index_Out,
    output logic             Result_Valid_Out
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LENGTH - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state_q;
    logic [IDX_W-1:0] count_q;
    logic             busy_q;
    logic [7:0]       run_max_q;
    logic [7:0]       run_min_q;
    logic [IDX_W-1:0] run_max_idx_q;
    logic [IDX_W-1:0] run_min_idx_q;
    logic [7:0]       max_q;
    logic [7:0]       min_q;
    logic [IDX_W-1:0] max_idx_q;
    logic [IDX_W-1:0] min_idx_q;
    logic             rv_q;

    // Candidate running values if the current sample is folded in.
    // Strict compares keep the earlier index on ties.
    logic             gt;
    logic             lt;
    logic             last;
    logic [7:0]       max_d;
    logic [7:0]       min_d;
    logic [IDX_W-1:0] max_idx_d;
    logic [IDX_W-1:0] min_idx_d;

    always_comb begin
        gt        = Data_In > run_max_q;
        lt        = Data_In < run_min_q;
        last      = count_q == LAST_IDX;
        max_d     = gt ? Data_In : run_max_q;
        min_d     = lt ? Data_In : run_min_q;
        max_idx_d = gt ? count_q : run_max_idx_q;
        min_idx_d = lt ? count_q : run_min_idx_q;
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q       <= IDLE;
            count_q       <= '0;
            busy_q        <= 1'b0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            run_max_idx_q <= '0;
            run_min_idx_q <= '0;
            max_q         <= '0;
            min_q         <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            rv_q          <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (Clear_In) begin
                // Abort drops the partial block and any sample offered with it.
                state_q       <= IDLE;
                count_q       <= '0;
                busy_q        <= 1'b0;
                run_max_q     <= '0;
                run_min_q     <= '0;
                run_max_idx_q <= '0;
                run_min_idx_q <= '0;
            end else if (Data_Valid_In) begin
                unique case (state_q)
                    IDLE: begin
                        state_q       <= ACCUM;
                        count_q       <= ONE;
                        busy_q        <= 1'b1;
                        run_max_q     <= Data_In;
                        run_min_q     <= Data_In;
                        run_max_idx_q <= '0;
                        run_min_idx_q <= '0;
                    end
                    ACCUM: begin
                        if (last) begin
                            // Publish directly from the folded values so the
                            // last sample takes part in the result.
                            max_q     <= max_d;
                            min_q     <= min_d;
                            max_idx_q <= max_idx_d;
                            min_idx_q <= min_idx_d;
                            rv_q      <= 1'b1;
                            state_q   <= IDLE;
                            count_q   <= '0;
                            busy_q    <= 1'b0;
                        end else begin
                            run_max_q     <= max_d;
                            run_min_q     <= min_d;
                            run_max_idx_q <= max_idx_d;
                            run_min_idx_q <= min_idx_d;
                            count_q       <= count_q + ONE;
                            busy_q        <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign Busy_Out         = busy_q;
    assign Sample_Count_Out = count_q;
    assign Max_Out          = max_q;
    assign Min_Out          = min_q;
    assign Max_Index_Out    = max_idx_q;
    assign Min_Index_Out    = min_idx_q;
    assign Result_Valid_Out = rv_q;

endmodule
